// File: rtl/router_port_arbiter.sv
// Round-robin arbiter with a one-entry output register for one mesh router output port.
// Includes a sticky watchdog that flags an output packet left unconsumed for TIMEOUT cycles.
module router_port_arbiter #(
  parameter int N_IN    = 5,
  parameter int PCK_SZ  = 40,
  parameter int TIMEOUT = 128,
  parameter int IDW     = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN*PCK_SZ-1:0] in_data,
  input  logic [N_IN-1:0]        in_pndng,
  input  logic [N_IN-1:0]        in_req,
  output logic [N_IN-1:0]        in_pop,
  output logic [PCK_SZ-1:0]      out_data,
  output logic                   out_pndng,
  input  logic                   out_pop,
  output logic [IDW-1:0]         out_src,
  output logic                   err_timeout
);

  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [IDW:0]    N_IN_W    = (IDW + 1)'(N_IN);
  localparam logic [IDW-1:0]  LAST_IDX  = IDW'(N_IN - 1);
  localparam logic [SW-1:0]   TIMEOUT_W = SW'(TIMEOUT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [N_IN-1:0]   elig;
  logic              any_elig;
  logic              load;
  logic [IDW-1:0]    win;
  logic              found;
  logic [IDW:0]      cand;
  logic [PCK_SZ-1:0] in_slice [N_IN];

  logic [IDW-1:0]    ptr_reg, ptr_next;
  logic [PCK_SZ-1:0] data_reg, data_next;
  logic [IDW-1:0]    src_reg, src_next;
  logic [SW-1:0]     stall_cnt_reg, stall_cnt_next;
  logic              err_reg, err_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      assign in_slice[gi] = in_data[gi*PCK_SZ +: PCK_SZ];
      assign elig[gi]     = in_pndng[gi] & in_req[gi];
      assign in_pop[gi]   = load && (win == IDW'(gi));
    end
  endgenerate

  assign any_elig = |elig;
  // Reset suppresses the pop so no packet is lost from an input FIFO.
  assign load = any_elig && ((state_reg == EMPTY) || out_pop) && !reset;

  // Rotating priority search starting at ptr, wrapping modulo N_IN.
  always_comb begin
    win   = ptr_reg;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand = {1'b0, ptr_reg} + (IDW + 1)'(k);
      if (cand >= N_IN_W) cand = cand - N_IN_W;
      if (!found && elig[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    data_next      = data_reg;
    src_next       = src_reg;
    stall_cnt_next = stall_cnt_reg;

    case (state_reg)
      EMPTY:   if (load) state_next = FULL;
      FULL:    if (out_pop && !load) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase

    if (load) begin
      data_next = in_slice[win];
      src_next  = win;
      ptr_next  = (win == LAST_IDX) ? '0 : win + IDW'(1);
    end

    // Counts only cycles where a held packet is refused downstream.
    if (load || out_pop || (state_reg == EMPTY))
      stall_cnt_next = '0;
    else if (stall_cnt_reg != TIMEOUT_W)
      stall_cnt_next = stall_cnt_reg + SW'(1);

    err_next = err_reg | (stall_cnt_next == TIMEOUT_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= EMPTY;
      ptr_reg       <= '0;
      data_reg      <= '0;
      src_reg       <= '0;
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      data_reg      <= data_next;
      src_reg       <= src_next;
      stall_cnt_reg <= stall_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign out_pndng   = (state_reg == FULL);
  assign out_data    = data_reg;
  assign out_src     = src_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed bench for router_port_arbiter: vector table for arbitration, hand sequences
// for idle-after-reset, watchdog timing and reset while holding a packet.
module tb_router_port_arbiter;

  localparam int N_IN    = 5;
  localparam int PCK_SZ  = 40;
  localparam int TIMEOUT = 128;
  localparam int IDW     = 3;

  logic                   clk;
  logic                   reset;
  logic [N_IN*PCK_SZ-1:0] in_data;
  logic [N_IN-1:0]        in_pndng;
  logic [N_IN-1:0]        in_req;
  logic [N_IN-1:0]        in_pop;
  logic [PCK_SZ-1:0]      out_data;
  logic                   out_pndng;
  logic                   out_pop;
  logic [IDW-1:0]         out_src;
  logic                   err_timeout;

  router_port_arbiter #(
    .N_IN(N_IN), .PCK_SZ(PCK_SZ), .TIMEOUT(TIMEOUT), .IDW(IDW)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_pndng(in_pndng),
    .in_req(in_req), .in_pop(in_pop), .out_data(out_data), .out_pndng(out_pndng),
    .out_pop(out_pop), .out_src(out_src), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_err = 1'b0;

  typedef struct {
    logic [4:0] pndng;
    logic [4:0] req;
    logic       opop;
    logic [4:0] exp_pop;
    logic       exp_pndng;
    logic [2:0] exp_src;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [PCK_SZ-1:0] pkt(input int i);
    return {8'hA5, 32'(i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    in_pndng = '0;
    in_req   = '0;
    out_pop  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_err = 1'b0;
  endtask

  // Drive one cycle of inputs, check the Mealy pop, then check registers after the edge.
  task automatic step(input string tag, input logic [4:0] pndng, input logic [4:0] req,
                      input logic opop, input logic [4:0] exp_pop, input logic exp_pndng,
                      input logic [2:0] exp_src);
    in_pndng = pndng;
    in_req   = req;
    out_pop  = opop;
    #1;
    check({tag, " in_pop"}, 64'(in_pop), 64'(exp_pop));
    @(posedge clk);
    #1;
    check({tag, " out_pndng"}, 64'(out_pndng), 64'(exp_pndng));
    check({tag, " out_src"}, 64'(out_src), 64'(exp_src));
    check({tag, " out_data"}, 64'(out_data), 64'(pkt(int'(exp_src))));
    check({tag, " err"}, 64'(err_timeout), 64'(exp_err));
    $display("%s pndng=%b req=%b opop=%b -> in_pop=%b out_pndng=%b src=%0d",
             tag, pndng, req, opop, in_pop, out_pndng, out_src);
  endtask

  initial begin
    // ptr starts at 0 with the port empty; each row's expectation follows from the prior row.
    vecs[0]  = '{5'b00100, 5'b00100, 1'b0, 5'b00100, 1'b1, 3'd2};
    vecs[1]  = '{5'b00100, 5'b00100, 1'b0, 5'b00000, 1'b1, 3'd2};
    vecs[2]  = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd2};
    vecs[3]  = '{5'b11111, 5'b11111, 1'b0, 5'b01000, 1'b1, 3'd3};
    vecs[4]  = '{5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4};
    vecs[5]  = '{5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
    vecs[6]  = '{5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1};
    vecs[7]  = '{5'b11111, 5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2};
    vecs[8]  = '{5'b11111, 5'b01010, 1'b1, 5'b01000, 1'b1, 3'd3};
    vecs[9]  = '{5'b11111, 5'b01010, 1'b1, 5'b00010, 1'b1, 3'd1};
    vecs[10] = '{5'b11111, 5'b01010, 1'b1, 5'b01000, 1'b1, 3'd3};
    vecs[11] = '{5'b11111, 5'b01010, 1'b0, 5'b00000, 1'b1, 3'd3};
    vecs[12] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd3};
    vecs[13] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd3};
    vecs[14] = '{5'b00001, 5'b11110, 1'b0, 5'b00000, 1'b0, 3'd3};
    vecs[15] = '{5'b10001, 5'b11111, 1'b0, 5'b10000, 1'b1, 3'd4};

    for (int i = 0; i < N_IN; i++) in_data[i*PCK_SZ +: PCK_SZ] = pkt(i);
    reset = 1'b1; in_pndng = '0; in_req = '0; out_pop = 1'b0;

    // Idle after reset
    apply_reset();
    check("rst out_pndng", 64'(out_pndng), 64'd0);
    check("rst out_src", 64'(out_src), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    for (int c = 0; c < 20; c++) begin
      check("idle in_pop", 64'(in_pop), 64'd0);
      check("idle out_pndng", 64'(out_pndng), 64'd0);
      check("idle err", 64'(err_timeout), 64'd0);
      @(posedge clk);
      #1;
    end
    $display("idle 20 cycles done out_pndng=%b err=%b", out_pndng, err_timeout);

    for (int v = 0; v < 16; v++)
      step($sformatf("vec%0d", v), vecs[v].pndng, vecs[v].req, vecs[v].opop,
           vecs[v].exp_pop, vecs[v].exp_pndng, vecs[v].exp_src);

    // Watchdog: err rises exactly TIMEOUT cycles after out_pndng rose
    apply_reset();
    step("wd load", 5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b1, 3'd0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      check("wd in_pop", 64'(in_pop), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("wd err k=%0d", k), 64'(err_timeout), 64'(k >= TIMEOUT));
    end
    $display("watchdog after %0d cycles err=%b", TIMEOUT, err_timeout);
    exp_err = 1'b1;
    step("wd drain", 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0);
    step("wd after", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0);

    // Reset while FULL with inputs 1 and 4 pending and ptr at 3
    apply_reset();
    step("mr load", 5'b00100, 5'b00100, 1'b0, 5'b00100, 1'b1, 3'd2);
    reset    = 1'b1;
    in_pndng = 5'b10010;
    in_req   = 5'b10010;
    out_pop  = 1'b1;
    #1;
    check("mr in_pop during reset", 64'(in_pop), 64'd0);
    @(posedge clk);
    #1;
    check("mr out_pndng", 64'(out_pndng), 64'd0);
    check("mr out_src", 64'(out_src), 64'd0);
    check("mr err", 64'(err_timeout), 64'd0);
    $display("mid reset out_pndng=%b src=%0d", out_pndng, out_src);
    reset   = 1'b0;
    exp_err = 1'b0;
    step("mr first", 5'b10010, 5'b10010, 1'b0, 5'b00010, 1'b1, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Round-robin arbiter and 1-entry output register for one output terminal of a mesh router.
- Up to N_IN input FIFOs (N, S, E, W, local) compete for the port; each presents a head packet (pndng/data) and is popped on grant.
- The winning packet is registered and offered downstream on the same pndng/pop handshake the router terminals use.
- A stall watchdog flags an output held longer than TIMEOUT cycles, matching the router's 128-cycle progress bound.

Parameters:
- N_IN, 5, number of requesting inputs (≥2)
- PCK_SZ, 40, packet width in bits
- TIMEOUT, 128, max cycles out_pndng may stay high without out_pop before err_timeout sets
- IDW, $clog2(N_IN), width of the grant index

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- in_data  in  N_IN*PCK_SZ  head packet of each input FIFO; slice i = [i*PCK_SZ +: PCK_SZ]
- in_pndng  in  N_IN  input FIFO i non-empty; in_data slice i valid
- in_req  in  N_IN  route logic says input i's head packet targets this port
- in_pop  out  N_IN  one-hot pop to the granted input FIFO
- out_data  out  PCK_SZ  registered packet offered downstream
- out_pndng  out  1  out_data valid
- out_pop  in  1  downstream consumes out_data
- out_src  out  IDW  input index that supplied out_data
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: out_data=0, out_pndng=0, out_src=0, ptr=0, stall_cnt=0, err_timeout=0. in_pop=0 during any cycle reset is high.
- elig[i] = in_pndng[i] & in_req[i].
- States are given by out_pndng:
  - EMPTY (0)
  - FULL (1)
- load = (|elig) & (EMPTY | (FULL & out_pop)).
- Winner w: first i with elig[i]=1, searching ptr, ptr+1, … N_IN-1, 0, … ptr-1 with wrap.
- in_pop is combinational (Mealy): in_pop[w]=1 only in a load cycle, otherwise all 0.
  - At most one bit is high.
  - No bit is ever high where in_pndng=0.
- On a load edge:
  - out_data <= in_data[w]
  - out_src <= w
  - out_pndng <= 1
  - ptr <= (w+1) mod N_IN
- FULL & out_pop & no elig: out_pndng <= 0. out_data and out_src hold their last value.
- FULL & out_pop & elig: reload the same cycle. out_pndng stays 1, giving 1 packet/cycle throughput.
- out_pop while EMPTY: ignored.
- FULL & !out_pop: all registers hold. in_pop=0 even if elig≠0.
- Latency: elig in cycle T with port EMPTY → in_pop high in T; out_pndng/out_data valid from T+1.
- ptr moves only on load. Requests arriving or leaving while FULL do not change ptr.
- Watchdog stall_cnt:
  - Saturating counter, width $clog2(TIMEOUT+1).
  - Cleared on load, on out_pop, or when EMPTY.
  - Increments when FULL & !out_pop.
  - When stall_cnt reaches TIMEOUT, err_timeout <= 1. It stays set until reset.
- Reset mid-operation: a packet held in the output register is discarded (out_pndng=0 next cycle). No pop is issued in the reset cycle.
- in_req for a non-pending input is a don't-care.

Test Plan:
- Reset then idle, all in_pndng=0 → out_pndng=0, in_pop=0, err_timeout=0 for 20 cycles.
- Input 2 only, in_pndng=in_req=5'b00100, data 40'hA5_0000_0002, out_pop=0 → in_pop=5'b00100 for exactly 1 cycle; next cycle out_pndng=1, out_data=40'hA5_0000_0002, out_src=2.
- All 5 inputs eligible continuously, out_pop=1 every cycle → grant order 0,1,2,3,4,0,…; one pop per cycle; out_src follows that sequence.
- in_pndng=5'b11111, in_req=5'b01010 → only inputs 1 and 3 are granted, alternating; in_pop[0], [2], [4] are never high.
- Packet loaded, out_pop held 0 → err_timeout rises exactly 128 cycles after out_pndng rose and stays 1 after a later out_pop; no further pops while FULL.
- FULL with inputs 1 and 4 pending, reset asserted for 1 cycle → next cycle out_pndng=0, ptr=0, in_pop=0 during reset; after release input 1 wins first.
